// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU sharing controller.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_MUL   = 4'd2;
    localparam logic [3:0] ALU_DIV   = 4'd3;
    localparam logic [7:0] DIV0_DATA = 8'hFF;

    function automatic logic is_div0(input logic [3:0] sel, input logic [7:0] b);
        return (sel == ALU_DIV) && (b == 8'd0);
    endfunction

    function automatic logic is_illegal(input logic [3:0] sel);
        return sel > ALU_DIV;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);

    logic [IDX_W-1:0] k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        k         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDX_W'((32'(ptr) + i) % N);
            if (!any_req && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = k;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU among NUM_REQ requesters: round-robin accept,
// issue/capture sequencing, tagged valid/ready response, div-by-zero guard.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    input  logic [NUM_REQ*4-1:0] req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_sel,
    input  logic [7:0]           alu_out,
    input  logic                 alu_carry,
    output logic                 busy,
    output logic [CNT_W-1:0]     ops_done
);

    state_t state, next_state;

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_req;

    logic [7:0] win_a;
    logic [7:0] win_b;
    logic [3:0] win_sel;
    logic       win_div0;
    logic       accept;
    logic       rsp_fire;
    logic [3:0] op_sel;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    always_comb begin
        win_a    = req_a[32'(grant_idx) * 8 +: 8];
        win_b    = req_b[32'(grant_idx) * 8 +: 8];
        win_sel  = req_sel[32'(grant_idx) * 4 +: 4];
        win_div0 = is_div0(win_sel, win_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant;
                accept    = any_req;
                if (any_req) begin
                    next_state = win_div0 ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign rsp_fire = rsp_valid & rsp_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // The ALU pin registers double as the operand latch; a div-by-zero never
    // loads them, so the ALU keeps its previous inputs untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            op_sel  <= '0;
        end else if (accept) begin
            op_sel <= win_sel;
            if (!win_div0) begin
                alu_a   <= win_a;
                alu_b   <= win_b;
                alu_sel <= win_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_id <= grant_idx;
            if (win_div0) begin
                rsp_data  <= DIV0_DATA;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b1;
            end
        end else if (state == CAPTURE) begin
            rsp_data  <= alu_out;
            rsp_carry <= (op_sel == ALU_ADD) & alu_carry;
            rsp_err   <= is_illegal(op_sel);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_done <= '0;
        end else if (rsp_fire) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule
